// File: rtl/wishbone_initiator.sv
// +----------------------------------------------------------------------------+
// | wishbone_initiator: single-transaction Wishbone classic-cycle initiator     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module wishbone_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUS  = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_dat;
  logic        r_rsp_err;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= c_IDLE;
      r_cnt       <= 8'd0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'd0;
      r_adr       <= 32'd0;
      r_dat       <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (cmd_valid_i) begin
            r_we    <= cmd_we_i;
            r_adr   <= cmd_adr_i;
            r_dat   <= cmd_dat_i;
            r_sel   <= cmd_sel_i;
            r_cnt   <= 8'd0;
            r_cyc   <= 1'b1;
            r_state <= c_BUS;
          end
        end
        c_BUS: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_rsp_dat   <= r_we ? 32'd0 : wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= c_RESP;
          end else if (r_cnt == c_TO_LAST) begin
            r_cyc       <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= c_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        c_RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= c_IDLE;
        end
        default: begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= c_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = (r_state == c_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_initiator.sv
// +----------------------------------------------------------------------------+
// | tb_wishbone_initiator: directed vectors plus multi-cycle corner sequences   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wishbone_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  // Slave model: mode 0 = ack after wait_n wait states, 1 = absent, 2 = ack stuck high
  int          ack_mode;
  int          wait_n;
  int          slv_cnt;
  logic [31:0] slv_dat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) slv_cnt <= wbm_cyc_o ? slv_cnt + 1 : 0;

  assign wbm_ack_i = (ack_mode == 2) || (ack_mode == 0 && wbm_cyc_o && slv_cnt == wait_n);
  assign wbm_dat_i = slv_dat;

  wishbone_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_sel_i  (cmd_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_dat_i  (wbm_dat_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          mode;
    int          wait_n;
    logic [31:0] sdat;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_vec(input int idx, input vec_t v);
    int  ncyc;
    bit  got;
    bit  first;
    @(negedge clk);
    ack_mode    = v.mode;
    wait_n      = v.wait_n;
    slv_dat     = v.sdat;
    cmd_we_i    = v.we;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.wdat;
    cmd_sel_i   = v.sel;
    cmd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the command inputs so the bus fields must come from latches.
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~v.we;
    cmd_adr_i   = ~v.adr;
    cmd_dat_i   = ~v.wdat;
    cmd_sel_i   = ~v.sel;
    ncyc  = 0;
    got   = 1'b0;
    first = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (first) begin
        chk($sformatf("v%0d ready_low", idx), {31'd0, cmd_ready_o}, 32'd0);
        chk($sformatf("v%0d stb_eq_cyc", idx), {31'd0, wbm_stb_o}, {31'd0, wbm_cyc_o});
        chk($sformatf("v%0d we", idx), {31'd0, wbm_we_o}, {31'd0, v.we});
        chk($sformatf("v%0d adr", idx), wbm_adr_o, v.adr);
        chk($sformatf("v%0d wdat", idx), wbm_dat_o, v.wdat);
        chk($sformatf("v%0d sel", idx), {28'd0, wbm_sel_o}, {28'd0, v.sel});
        first = 1'b0;
      end
      if (rsp_valid_o) got = 1'b1;
      else if (wbm_cyc_o) ncyc++;
    end
    chk($sformatf("v%0d rsp_seen", idx), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d cyc_cycles", idx), ncyc, v.exp_cyc);
    chk($sformatf("v%0d cyc_low_at_rsp", idx), {31'd0, wbm_cyc_o}, 32'd0);
    chk($sformatf("v%0d err", idx), {31'd0, rsp_err_o}, {31'd0, v.exp_err});
    chk($sformatf("v%0d rdat", idx), rsp_dat_o, v.exp_dat);
    @(negedge clk);
    chk($sformatf("v%0d valid_drop", idx), {31'd0, rsp_valid_o}, 32'd0);
    chk($sformatf("v%0d ready_back", idx), {31'd0, cmd_ready_o}, 32'd1);
    chk($sformatf("v%0d rdat_hold", idx), rsp_dat_o, v.exp_dat);
  endtask

  initial begin
    int seen;
    vecs[0] = '{1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h5555_AAAA, 1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 0, 2, 32'h1234_5678, 3, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1, 0, 32'hFFFF_0000, 4, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 0, 3, 32'hA5A5_A5A5, 4, 1'b0, 32'hA5A5_A5A5};
    vecs[4] = '{1'b1, 32'h3000_0008, 32'h0BAD_F00D, 4'h3, 0, 1, 32'h7777_7777, 2, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h3000_000C, 32'h0,         4'h1, 0, 0, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D};

    rst = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'b0;
    cmd_adr_i = 32'h0;
    cmd_dat_i = 32'h0;
    cmd_sel_i = 4'h0;
    ack_mode = 1;
    wait_n = 0;
    slv_dat = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst err", {31'd0, rsp_err_o}, 32'd0);
    chk("rst rdat", rsp_dat_o, 32'd0);
    chk("rst cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst stb", {31'd0, wbm_stb_o}, 32'd0);
    chk("rst we", {31'd0, wbm_we_o}, 32'd0);
    chk("rst sel", {28'd0, wbm_sel_o}, 32'd0);
    chk("rst adr", wbm_adr_o, 32'd0);
    chk("rst wdat", wbm_dat_o, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) do_vec(k, vecs[k]);

    // Back-to-back with cmd_valid held and ack stuck high.
    @(negedge clk);
    ack_mode = 2;
    slv_dat = 32'h1111_1111;
    cmd_we_i = 1'b0;
    cmd_adr_i = 32'h3000_0010;
    cmd_sel_i = 4'hF;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    chk("b2b c1 cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("b2b c1 adr", wbm_adr_o, 32'h3000_0010);
    @(negedge clk);
    chk("b2b c1 cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
    chk("b2b c1 valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("b2b c1 rdat", rsp_dat_o, 32'h1111_1111);
    slv_dat = 32'h2222_2222;
    cmd_adr_i = 32'h3000_0014;
    @(negedge clk);
    chk("b2b idle ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("b2b idle valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("b2b idle cyc", {31'd0, wbm_cyc_o}, 32'd0);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("b2b c2 cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("b2b c2 adr", wbm_adr_o, 32'h3000_0014);
    chk("b2b c2 no_early_rsp", {31'd0, rsp_valid_o}, 32'd0);
    @(negedge clk);
    chk("b2b c2 cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
    chk("b2b c2 valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("b2b c2 rdat", rsp_dat_o, 32'h2222_2222);
    @(negedge clk);

    // Reset mid-BUS against an absent slave.
    ack_mode = 1;
    cmd_adr_i = 32'h3000_0020;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("rstbus cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstbus cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rstbus stb", {31'd0, wbm_stb_o}, 32'd0);
    chk("rstbus ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rstbus rdat", rsp_dat_o, 32'd0);
    chk("rstbus adr", wbm_adr_o, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid_o || wbm_cyc_o) seen++;
    end
    chk("rstbus no_rsp", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wishbone_initiator.md
# wishbone_initiator

Single-transaction Wishbone classic-cycle initiator: it accepts one command (address, data, write enable, byte selects) on a valid/ready handshake and runs one bus cycle against user-project Wishbone registers in the 0x3000_0000 window. It returns read data or a timeout error on a one-cycle response strobe. It sits on the test/bring-up side of our Wishbone register blocks, so the design can exercise them in simulation and from on-chip sequencers without a CPU model.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, number of sampled BUS-state clock edges without ack before the cycle is abandoned; legal range 1..255.

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  block can accept a command; high exactly in IDLE.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  target byte address.
- cmd_dat_i  in  32  write data; ignored for reads.
- cmd_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_dat_o  out  32  read data; 0 for writes and on error.
- rsp_err_o  out  1  qualifies rsp_valid_o; 1 = timeout.
- wbm_cyc_o, wbm_stb_o  out  1 each  bus cycle/strobe; always driven equal.
- wbm_we_o  out  1  latched cmd_we_i.
- wbm_sel_o  out  4  latched cmd_sel_i.
- wbm_adr_o  out  32  latched cmd_adr_i.
- wbm_dat_o  out  32  latched cmd_dat_i.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.

## Operation
- States: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready_o = 1.
  - On an edge with cmd_valid_i = 1: latch we/adr/dat/sel into wbm_* registers, clear the timeout counter, assert wbm_cyc_o/wbm_stb_o, go to BUS.
  - wbm_ack_i is ignored.
- BUS:
  - cmd_ready_o = 0. wbm_cyc_o/wbm_stb_o = 1 and all wbm_* outputs are held stable.
  - On each edge, sample wbm_ack_i.
  - If ack = 1:
    - Deassert cyc/stb.
    - For a read, capture wbm_dat_i into rsp_dat_o; for a write, set rsp_dat_o = 0.
    - Set rsp_err_o = 0, go to RESP.
  - Else, if the counter equals TIMEOUT_CYCLES-1: deassert cyc/stb, set rsp_dat_o = 0 and rsp_err_o = 1, go to RESP.
  - Else, increment the counter (8-bit, never wraps within the legal range).
  - Ack and timeout on the same edge: ack wins and the response is normal.
  - Ack on the first BUS edge is accepted, so combinational slaves respond in zero wait states.
- RESP:
  - rsp_valid_o = 1 for exactly this one cycle.
  - Next edge: go to IDLE, clear rsp_valid_o. rsp_dat_o and rsp_err_o hold until the next response.
  - wbm_ack_i is ignored here and in IDLE, including a slave that holds ack high after its cycle.
- No response backpressure: the consumer must take rsp_* in the strobe cycle.
- Reset at any time, including mid-BUS:
  - The next edge forces IDLE and drops cyc/stb.
  - No rsp_valid_o is produced for the abandoned transaction.
  - All registered outputs are cleared.

## Timing
- Reset values:
  - cmd_ready_o = 1 (IDLE decode).
  - rsp_valid_o = 0, rsp_err_o = 0, rsp_dat_o = 0.
  - wbm_cyc_o = 0, wbm_stb_o = 0, wbm_we_o = 0, wbm_sel_o = 0, wbm_adr_o = 0, wbm_dat_o = 0.
- Timing reference: command accepted at edge E0; cyc/stb are high from E0+.
- Zero-wait slave (ack high during the cycle after E0):
  - Ack sampled at E1; cyc/stb low after E1.
  - rsp_valid_o high E1..E2; cmd_ready_o high again after E2.
- Slave with k wait states: response strobe after edge E(1+k).
- Minimum command-to-command period: 3 cycles.
- Timeout: the strobe occurs after edge E(TIMEOUT_CYCLES); cyc has been high for exactly TIMEOUT_CYCLES cycles.
- cmd_ready_o is a pure decode of state, with no combinational path from cmd_valid_i.

## Test plan
- Write to a register at 0x3000_0000 with dat 0xDEADBEEF, sel 0xF; the slave acks zero-wait -> cyc/stb high exactly 1 cycle, wbm_we_o = 1, wbm_dat_o = 0xDEADBEEF, then rsp_valid_o pulse with err = 0 and dat = 0.
- Read from 0x3000_0000; the slave acks after 2 wait states with 0x12345678 -> cyc high 3 cycles, rsp_dat_o = 0x12345678, err = 0.
- TIMEOUT_CYCLES = 4, read 0x3000_0004 with no slave -> cyc high exactly 4 cycles, rsp_valid_o with err = 1 and dat = 0.
- Ack arrives on the timeout edge (TIMEOUT_CYCLES = 4, ack on the 4th sampled edge), read data 0xA5A5A5A5 -> err = 0, dat = 0xA5A5A5A5.
- Back-to-back with cmd_valid_i held high and a slave whose ack sticks high -> both commands complete with 1-cycle bus phases, and the 2nd cycle is not acked early in IDLE/RESP.
- wb_rst_i asserted for 1 cycle mid-BUS -> cyc/stb low after that edge, no rsp_valid_o, and cmd_ready_o = 1 after the reset edge.
